dsp_detect_ctrl: RTL

DSP_DETECT_CTRL -- requirements
Module: dsp_detect_ctrl

---
 rtl/dsp_pkg.sv | 12 +
 rtl/dsp_holdoff_timer.sv | 39 +++
 rtl/dsp_detect_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP constants: sample width and detect-controller state encoding.
package dsp_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/dsp_holdoff_timer.sv
// Post-event holdoff down-counter. i_load starts a run of exactly
// HOLDOFF_CYCLES cycles (counting the first cycle after the load edge);
// o_done is high during the last of those cycles. i_clr aborts the run.
module dsp_holdoff_timer #(
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_clr,
  output logic o_done
);

  localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_V = CW'(HOLDOFF_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          busy_q;

  // Load to N-1 so the zero count lands on the N-th holdoff cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_clr) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_load) begin
      cnt_q  <= LOAD_V;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign o_done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/dsp_detect_ctrl.sv
// Detection controller: qualifies consecutive threshold-detector hits,
// emits a one-cycle confirmed event, then holds off for HOLDOFF_CYCLES.
// Optional feature: define DSP_DETECT_CTRL_EVCNT_EN to add o_event_count,
// a saturating count of o_event pulses cleared by accepted config writes.
module dsp_detect_ctrl
  import dsp_pkg::*;
#(
  parameter int               CONFIRM_W      = 4,
  parameter int               HOLDOFF_CYCLES = 1000,
  parameter logic [ADC_W-1:0] THRESH_RST     = 12'hFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_arm,
  input  logic                 i_disarm,
  input  logic                 i_cfg_wr,
  input  logic [ADC_W-1:0]     i_cfg_threshold,
  input  logic [CONFIRM_W-1:0] i_cfg_confirm,
  input  logic                 i_sample_valid,
  input  logic                 i_detected,
  output logic [ADC_W-1:0]     o_threshold,
  output logic                 o_armed,
  output logic                 o_event,
  output logic                 o_cfg_err,
  output logic [1:0]           o_state
`ifdef DSP_DETECT_CTRL_EVCNT_EN
  ,
  output logic [15:0]          o_event_count
`endif
);

  state_e               state_q;
  logic [CONFIRM_W-1:0] confirm_q;
  logic [CONFIRM_W-1:0] run_q;
  logic [CONFIRM_W:0]   run_inc;
  logic                 hit;
  logic                 ho_load;
  logic                 ho_done;

  // One extra bit so run+1 never wraps before comparing against confirm.
  assign run_inc = {1'b0, run_q} + (CONFIRM_W+1)'(1);
  assign hit     = i_sample_valid && i_detected && (run_inc == {1'b0, confirm_q});
  assign ho_load = (state_q == ARMED) && !i_disarm && hit;

  dsp_holdoff_timer #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(ho_load),
    .i_clr (i_disarm),
    .o_done(ho_done)
  );

  // Control FSM with config registers, run counter and pulse outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      o_threshold <= THRESH_RST;
      confirm_q   <= CONFIRM_W'(1);
      run_q       <= '0;
      o_event     <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      o_event   <= 1'b0;
      o_cfg_err <= 1'b0;
      // Config is only accepted while idle; elsewhere it is flagged.
      if (i_cfg_wr) begin
        if (state_q == IDLE) begin
          o_threshold <= i_cfg_threshold;
          confirm_q   <= (i_cfg_confirm == '0) ? CONFIRM_W'(1) : i_cfg_confirm;
        end else begin
          o_cfg_err <= 1'b1;
        end
      end
      if (i_disarm) begin
        state_q <= IDLE;
        run_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_arm) begin
              state_q <= ARMED;
              run_q   <= '0;
            end
          end
          ARMED: begin
            if (i_sample_valid) begin
              if (!i_detected) begin
                run_q <= '0;
              end else if (hit) begin
                o_event <= 1'b1;
                state_q <= HOLDOFF;
                run_q   <= '0;
              end else if (run_q != '1) begin
                run_q <= run_inc[CONFIRM_W-1:0];
              end
            end
          end
          HOLDOFF: begin
            if (ho_done) begin
              state_q <= ARMED;
              run_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_state = state_q;
  assign o_armed = (state_q == ARMED) || (state_q == HOLDOFF);

`ifdef DSP_DETECT_CTRL_EVCNT_EN
  // Saturating event counter; an accepted config write starts a new tally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              o_event_count <= '0;
    else if (i_cfg_wr && state_q == IDLE)   o_event_count <= '0;
    else if (o_event && o_event_count != '1) o_event_count <= o_event_count + 16'd1;
  end
`endif

endmodule
